ddio_in_capture: RTL and testbench



---
 rtl/ddio_in_capture.sv | 54 +++++
 tb/tb_ddio_in_capture.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ddio_in_capture.sv
// rtl/ddio_in_capture.sv - double-data-rate input capture register for the ADC LVDS data lanes
//
// Ports:
//   inclock    bit clock; both of its edges sample datain
//   aclr       asynchronous active-high clear of every register
//   inclocken  capture enable, sampled on each edge (1 = capture)
//   datain     DDR serial data, one bit per lane
//   dataout_h  datain at the most recent rising edge (later-in-time bit)
//   dataout_l  datain at the falling edge just before that rising edge
module ddio_in_capture #(
    parameter int WIDTH         = 8,
    parameter int POWER_UP_HIGH = 0
) (
    input  logic             inclock,
    input  logic             aclr,
    input  logic             inclocken,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout_h,
    output logic [WIDTH-1:0] dataout_l
);

    localparam logic [WIDTH-1:0] RST_VAL = (POWER_UP_HIGH != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // Declaration values give the power-up state, identical to the reset state.
    logic [WIDTH-1:0] reg_h   = RST_VAL;
    logic [WIDTH-1:0] reg_neg = RST_VAL;
    logic [WIDTH-1:0] reg_l   = RST_VAL;

    // Falling-edge sample; only lives for half a period before being
    // moved into the rising-edge domain by reg_l.
    always_ff @(negedge inclock or posedge aclr) begin
        if (aclr) begin
            reg_neg <= RST_VAL;
        end else if (inclocken) begin
            reg_neg <= datain;
        end
    end

    // Both output registers update on the same rising edge so the h/l pair
    // stays coherent for the whole following period.
    always_ff @(posedge inclock or posedge aclr) begin
        if (aclr) begin
            reg_h <= RST_VAL;
            reg_l <= RST_VAL;
        end else if (inclocken) begin
            reg_h <= datain;
            reg_l <= reg_neg;
        end
    end

    assign dataout_h = reg_h;
    assign dataout_l = reg_l;

endmodule

// File: tb/tb_ddio_in_capture.sv
// tb/tb_ddio_in_capture.sv - self-checking bench for ddio_in_capture
module tb_ddio_in_capture;

    logic       inclock = 1'b0;
    logic       aclr;
    logic       inclocken;
    logic [7:0] datain;
    logic [7:0] h0, l0, h1, l1;

    int checks = 0;
    int errors = 0;

    // Reference: the outputs are simply the last accepted (falling, rising)
    // sample pair, or the reset value where no such sample exists yet.
    logic [7:0] m_h, m_l;
    bit         h_ok, l_ok;

    ddio_in_capture #(.WIDTH(8), .POWER_UP_HIGH(0)) dut_lo (
        .inclock   (inclock),
        .aclr      (aclr),
        .inclocken (inclocken),
        .datain    (datain),
        .dataout_h (h0),
        .dataout_l (l0)
    );

    ddio_in_capture #(.WIDTH(8), .POWER_UP_HIGH(1)) dut_hi (
        .inclock   (inclock),
        .aclr      (aclr),
        .inclocken (inclocken),
        .datain    (datain),
        .dataout_h (h1),
        .dataout_l (l1)
    );

    always #5 inclock = ~inclock;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, "_h_pu0"}, h0, h_ok ? m_h : 8'h00);
        cmp({tag, "_l_pu0"}, l0, l_ok ? m_l : 8'h00);
        cmp({tag, "_h_pu1"}, h1, h_ok ? m_h : 8'hFF);
        cmp({tag, "_l_pu1"}, l1, l_ok ? m_l : 8'hFF);
    endtask

    // Entered just after a rising edge; drives nv for the falling edge and
    // pv for the rising edge, and leaves just after that rising edge.
    task automatic cycle(input string tag, input logic [7:0] nv, input logic [7:0] pv, input bit en);
        datain    = nv;
        inclocken = en;
        @(negedge inclock);
        #1;
        check_all({tag, "_mid"});
        datain = pv;
        @(posedge inclock);
        #1;
        if (!aclr && en) begin
            m_h  = pv;
            m_l  = nv;
            h_ok = 1'b1;
            l_ok = 1'b1;
        end
        check_all(tag);
    endtask

    initial begin
        aclr      = 1'b1;
        inclocken = 1'b1;
        datain    = 8'hFF;
        h_ok      = 1'b0;
        l_ok      = 1'b0;
        m_h       = 8'h00;
        m_l       = 8'h00;
        #1;
        check_all("reset_t0");
        @(posedge inclock);
        #1;
        for (int i = 0; i < 3; i++) cycle("reset_clk", 8'hFF, 8'hFF, 1'b1);

        aclr = 1'b0;
        cycle("basic", 8'h3C, 8'hA5, 1'b1);

        for (int i = 0; i < 16; i++) cycle("stream", 8'h55, 8'hAA, 1'b1);
        cycle("swap", 8'hAA, 8'h55, 1'b1);
        cycle("swap2", 8'hAA, 8'h55, 1'b1);

        for (int i = 0; i < 3; i++) cycle("en_low", 8'h0F, 8'h0F, 1'b0);
        cycle("en_high", 8'h12, 8'h34, 1'b1);

        // Asynchronous clear between a falling and a rising edge.
        datain = 8'hC3;
        @(negedge inclock);
        #1;
        aclr = 1'b1;
        h_ok = 1'b0;
        l_ok = 1'b0;
        #1;
        check_all("midrst_async");
        datain = 8'h7E;
        #1;
        aclr = 1'b0;
        @(posedge inclock);
        #1;
        m_h  = 8'h7E;
        h_ok = 1'b1;
        check_all("midrst_release");

        for (int i = 0; i < 8; i++) begin
            logic [7:0] one;
            one = 8'h01 << i;
            cycle("walk", one, 8'h00, 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] nv, pv;
            bit         en;
            nv = 8'($urandom);
            pv = 8'($urandom);
            en = ($urandom_range(0, 3) != 0);
            cycle("rand", nv, pv, en);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
